score_pips: RTL and testbench
=============================

SCORE_PIPS -- requirements
Module: score_pips

Interface
REQ-001 SHALL have parameter MAX_POINTS, default 5, pips per player and winning score (1..15).
REQ-002 SHALL have parameter PIP_W, default 5, pip width in pixels.
REQ-003 SHALL have parameter PIP_H, default 5, pip height in pixels.
REQ-004 SHALL have parameter START_Y_LOC, default 15, top row of all pips.
REQ-005 SHALL have parameter P1_X_LOC, default 4, left column of player-1 pip 0.
REQ-006 SHALL have parameter P2_X_LOC, default 132, left column of player-2 pip 0.
REQ-007 SHALL have parameter BLINK_FRAMES, default 30, frame ticks per blink half-period.
REQ-008 SHALL have ports: clk  in  1  system clock; one clock only.
REQ-009 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have ports: counter_x  in  10  pixel column; counter_y  in  10  pixel row.
REQ-011 SHALL have port: frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 SHALL have ports: p1_score_inc, p2_score_inc  in  1  one-cycle point-scored pulses.
REQ-013 SHALL have port: game_clear  in  1  one-cycle pulse, restart match.
REQ-014 SHALL have ports: p1_score, p2_score  out  4  current scores.
REQ-015 SHALL have ports: game_over  out  1; winner  out  2 (01 P1, 10 P2, 11 draw, 00 none).
REQ-016 SHALL have port: draw_points  out  1  registered pixel-on for pip graphics.

Function
REQ-017 SHALL implement two states: PLAY, OVER.
REQ-018 In PLAY, an inc pulse SHALL add 1 to that player's score on the next clock edge.
REQ-019 Simultaneous p1/p2 inc pulses SHALL both be applied in the same cycle.
REQ-020 A score reaching MAX_POINTS SHALL move the FSM to OVER and set game_over=1 next cycle, registered together with the score.
REQ-021 winner SHALL be 01/10 for a single player at MAX_POINTS; 11 if both reach it in the same cycle.
REQ-022 In OVER, inc pulses SHALL be ignored; scores SHALL never exceed MAX_POINTS.
REQ-023 game_clear SHALL, on the next edge, zero scores, winner, game_over and the blink state, and enter PLAY.
REQ-024 game_clear SHALL take precedence over inc pulses in the same cycle.
REQ-025 Pip k (0..MAX_POINTS-1) of player p SHALL occupy x in [Px_X_LOC+k*PIP_W, Px_X_LOC+(k+1)*PIP_W) and y in [START_Y_LOC, START_Y_LOC+PIP_H).
REQ-026 Pip k SHALL be drawn filled when k < score; otherwise only its 1-pixel border SHALL be drawn.
REQ-027 draw_points SHALL be the OR over all pips, registered with 1-cycle latency from counter_x/counter_y.
REQ-028 Geometry arithmetic SHALL use at least 11 bits so that pip bounds do not wrap.

Reset
REQ-029 While rst=1, SHALL force scores=0, state=PLAY, game_over=0, winner=00, draw_points=0, blink counter=0, blink phase=0.
REQ-030 rst asserted mid-match SHALL discard the score immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro SCORE_BLINK_EN defined: in OVER, a counter SHALL count frame_tick pulses and toggle the blink phase every BLINK_FRAMES ticks.
REQ-032 While the blink phase is 1, the winner's pips SHALL be suppressed. A draw suppresses both players' pips.
REQ-033 Macro SCORE_BLINK_EN absent: no blink logic; pips SHALL be drawn steadily in OVER, and frame_tick SHALL be unused.

Verification
REQ-034 Reset, then scan (x=4..28, y=15..19) -> draw_points shows only borders, 1 cycle late; scores 0.
REQ-035 Three p1_score_inc pulses -> p1_score=3; pixels (6,17),(11,17),(16,17) on; (21,17) off; (19,15) on.
REQ-036 p1=4, p2=4, both inc same cycle -> scores 5/5, game_over=1, winner=11 next cycle.
REQ-037 p2 reaches 5, then further p1/p2 inc pulses -> scores frozen, winner=10; game_clear together with inc -> scores 0, PLAY.
REQ-038 SCORE_BLINK_EN with BLINK_FRAMES=2, P1 wins -> P1 pips off after 2 frame_ticks, back on after 4; P2 pips steady.
REQ-039 rst asserted mid-match with p1=2 -> p1_score=0 and draw_points=0 before the next clk edge.

Source files
------------

// File: rtl/score_pips.sv
// Two-player pip scoreboard: PLAY/OVER match FSM, score registers and registered pip graphics.
// Optional SCORE_BLINK_EN: the winner's pips blink in OVER, paced by frame_tick.
module score_pips #(
    parameter int MAX_POINTS   = 5,
    parameter int PIP_W        = 5,
    parameter int PIP_H        = 5,
    parameter int START_Y_LOC  = 15,
    parameter int P1_X_LOC     = 4,
    parameter int P2_X_LOC     = 132,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       frame_tick,
    input  logic       p1_score_inc,
    input  logic       p2_score_inc,
    input  logic       game_clear,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw_points,
    output logic       state_dbg
);

    localparam int GW = 12;
    localparam logic [3:0] MAX_SCORE = 4'(MAX_POINTS);
    localparam int BLINK_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic [1:0] winner_q, winner_d;
    logic       draw_points_q, draw_points_d;
    logic [3:0] p1_next, p2_next;
    logic       p1_hit, p2_hit;
    logic       blink_phase;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and score update
    // ------------------------------------------------------------------
    always_comb begin
        p1_next    = p1_score_q + {3'b000, p1_score_inc};
        p2_next    = p2_score_q + {3'b000, p2_score_inc};
        p1_hit     = (p1_next == MAX_SCORE);
        p2_hit     = (p2_next == MAX_SCORE);
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        if (game_clear) begin
            state_d    = ST_PLAY;
            p1_score_d = 4'd0;
            p2_score_d = 4'd0;
            winner_d   = 2'b00;
        end else if (state_q == ST_PLAY) begin
            // Scores are below MAX in PLAY, so a single increment cannot overshoot.
            p1_score_d = p1_next;
            p2_score_d = p2_next;
            if (p1_hit || p2_hit) begin
                state_d  = ST_OVER;
                winner_d = {p2_hit, p1_hit};
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        game_over   = (state_q == ST_OVER);
        state_dbg   = state_q;
        p1_score    = p1_score_q;
        p2_score    = p2_score_q;
        winner      = winner_q;
        draw_points = draw_points_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_score_q    <= 4'd0;
            p2_score_q    <= 4'd0;
            winner_q      <= 2'b00;
            draw_points_q <= 1'b0;
        end else begin
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            winner_q      <= winner_d;
            draw_points_q <= draw_points_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink timing
    // ------------------------------------------------------------------
`ifdef SCORE_BLINK_EN
    localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_FRAMES - 1);

    logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (game_clear) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if ((state_q == ST_OVER) && frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    logic unused_blink_inputs;
    logic [BLINK_CW-1:0] unused_blink_width;

    assign unused_blink_inputs = frame_tick & (BLINK_FRAMES > 0);
    assign unused_blink_width  = '0;
    assign blink_phase         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pip graphics
    // ------------------------------------------------------------------
    // Pixel-on test for one player's row of pips; 12-bit math keeps bounds from wrapping.
    function automatic logic pip_pixel(input logic [GW-1:0] x,
                                       input logic [GW-1:0] y,
                                       input logic [GW-1:0] x_loc,
                                       input logic [3:0]    score);
        logic          hit;
        logic [GW-1:0] x0;
        logic [GW-1:0] x1;
        logic [GW-1:0] y0;
        logic [GW-1:0] y1;
        hit = 1'b0;
        y0  = GW'(START_Y_LOC);
        y1  = GW'(START_Y_LOC + PIP_H);
        for (int k = 0; k < MAX_POINTS; k++) begin
            x0 = x_loc + GW'(k * PIP_W);
            x1 = x0 + GW'(PIP_W);
            if ((x >= x0) && (x < x1) && (y >= y0) && (y < y1)) begin
                if (k < int'(score)) begin
                    hit = 1'b1;
                end else if ((x == x0) || (x == x1 - 1'b1) ||
                             (y == y0) || (y == y1 - 1'b1)) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    logic [GW-1:0] pix_x, pix_y;
    logic          p1_on, p2_on, p1_sup, p2_sup;

    always_comb begin
        pix_x  = {2'b00, counter_x};
        pix_y  = {2'b00, counter_y};
        p1_on  = pip_pixel(pix_x, pix_y, GW'(P1_X_LOC), p1_score_q);
        p2_on  = pip_pixel(pix_x, pix_y, GW'(P2_X_LOC), p2_score_q);
        // A draw sets both winner bits, so both rows blink together.
        p1_sup = blink_phase & winner_q[0];
        p2_sup = blink_phase & winner_q[1];
        draw_points_d = (p1_on & ~p1_sup) | (p2_on & ~p2_sup);
    end

endmodule

// File: tb/tb_score_pips.sv
// Directed bench for score_pips: reset, pip scan, scoring, draw/win, freeze, clear precedence,
// blink (when SCORE_BLINK_EN is defined) and asynchronous mid-match reset.
module tb_score_pips;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] counter_x, counter_y;
    logic       frame_tick, p1_score_inc, p2_score_inc, game_clear;
    logic [3:0] p1_score, p2_score;
    logic       game_over;
    logic [1:0] winner;
    logic       draw_points;
    logic       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SCORE_BLINK_EN
    localparam logic BLINK_ON = 1'b1;
`else
    localparam logic BLINK_ON = 1'b0;
`endif

    score_pips #(.BLINK_FRAMES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .frame_tick  (frame_tick),
        .p1_score_inc(p1_score_inc),
        .p2_score_inc(p2_score_inc),
        .game_clear  (game_clear),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .game_over   (game_over),
        .winner      (winner),
        .draw_points (draw_points),
        .state_dbg   (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int x, input int y);
        counter_x = 10'(x);
        counter_y = 10'(y);
    endtask

    task automatic px_check(input string tag, input int x, input int y, input logic exp);
        set_px(x, y);
        tick();
        check(tag, 32'(draw_points), 32'(exp));
    endtask

    task automatic pulse(input logic a, input logic b, input logic c);
        p1_score_inc = a;
        p2_score_inc = b;
        game_clear   = c;
        tick();
        p1_score_inc = 1'b0;
        p2_score_inc = 1'b0;
        game_clear   = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic check_match(input string tag, input int s1, input int s2,
                               input logic go, input logic [1:0] w);
        check({tag, "_p1"}, 32'(p1_score), 32'(s1));
        check({tag, "_p2"}, 32'(p2_score), 32'(s2));
        check({tag, "_go"}, 32'(game_over), 32'(go));
        check({tag, "_win"}, 32'(winner), 32'(w));
        check({tag, "_st"}, 32'(state_dbg), 32'(go));
    endtask

    // Border rule for player-1 pips with score 0 inside x 4..28, y 15..19.
    function automatic logic border_px(input int x, input int y);
        return (y == 15) || (y == 19) || (((x - 4) % 5) == 0) || (((x - 4) % 5) == 4);
    endfunction

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        p1_score_inc = 1'b0;
        p2_score_inc = 1'b0;
        game_clear = 1'b0;
        set_px(4, 15);
        repeat (3) tick();
        check_match("reset", 0, 0, 1'b0, 2'b00);
        check("reset_draw", 32'(draw_points), 32'd0);
        rst = 1'b0;

        // empty pips: borders only, one cycle late
        for (int y = 15; y <= 19; y++)
            for (int x = 4; x <= 28; x++)
                px_check($sformatf("scan_%0d_%0d", x, y), x, y, border_px(x, y));
        px_check("left_out", 3, 17, 1'b0);
        px_check("right_out", 29, 17, 1'b0);
        px_check("above_out", 4, 14, 1'b0);
        px_check("below_out", 4, 20, 1'b0);
        px_check("lat_a", 4, 17, 1'b1);
        set_px(6, 17);
        #1;
        check("lat_hold", 32'(draw_points), 32'd1);
        tick();
        check("lat_b", 32'(draw_points), 32'd0);

        // frame ticks in PLAY must not disturb anything
        frames(3);
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        check_match("three", 3, 0, 1'b0, 2'b00);
        px_check("f_6_17", 6, 17, 1'b1);
        px_check("f_11_17", 11, 17, 1'b1);
        px_check("f_16_17", 16, 17, 1'b1);
        px_check("e_21_17", 21, 17, 1'b0);
        px_check("b_19_15", 19, 15, 1'b1);
        px_check("p2_in", 134, 17, 1'b0);
        px_check("p2_edge", 132, 17, 1'b1);

        // simultaneous winning increments give a draw
        pulse(1'b1, 1'b0, 1'b0);
        repeat (4) pulse(1'b0, 1'b1, 1'b0);
        check_match("four4", 4, 4, 1'b0, 2'b00);
        pulse(1'b1, 1'b1, 1'b0);
        check_match("draw", 5, 5, 1'b1, 2'b11);
        set_px(6, 17);
        frames(2);
        tick();
        check("draw_blink_p1", 32'(draw_points), 32'(!BLINK_ON));
        set_px(134, 17);
        tick();
        check("draw_blink_p2", 32'(draw_points), 32'(!BLINK_ON));
        set_px(6, 17);
        frames(2);
        tick();
        check("draw_unblink", 32'(draw_points), 32'd1);

        pulse(1'b0, 1'b0, 1'b1);
        check_match("clear1", 0, 0, 1'b0, 2'b00);
        px_check("clear1_px", 7, 17, 1'b0);

        // P2 wins, further increments ignored, clear beats inc
        repeat (5) pulse(1'b0, 1'b1, 1'b0);
        check_match("p2win", 0, 5, 1'b1, 2'b10);
        pulse(1'b1, 1'b1, 1'b0);
        check_match("frozen", 0, 5, 1'b1, 2'b10);
        pulse(1'b1, 1'b1, 1'b1);
        check_match("clr_inc", 0, 0, 1'b0, 2'b00);
        pulse(1'b1, 1'b0, 1'b0);
        check_match("replay", 1, 0, 1'b0, 2'b00);

        // P1 wins: only P1 pips blink
        repeat (4) pulse(1'b1, 1'b0, 1'b0);
        check_match("p1win", 5, 0, 1'b1, 2'b01);
        px_check("p1win_on", 6, 17, 1'b1);
        frames(2);
        tick();
        check("p1_blink_off", 32'(draw_points), 32'(!BLINK_ON));
        px_check("p2_steady", 132, 17, 1'b1);
        set_px(6, 17);
        frames(2);
        tick();
        check("p1_blink_on", 32'(draw_points), 32'd1);

        // asynchronous reset mid-match
        pulse(1'b0, 1'b0, 1'b1);
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check("mid_p1", 32'(p1_score), 32'd2);
        px_check("mid_px", 7, 17, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_p1", 32'(p1_score), 32'd0);
        check("async_draw", 32'(draw_points), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_match("post_rst", 0, 0, 1'b0, 2'b00);
        px_check("post_rst_px", 7, 17, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
